// File: rtl/divider_param_if.sv
// Start/operand and result/status bundle for the iterative divider.
// master drives requests; slave is the divider itself.
interface divider_param_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_DIV;
    logic             ctrl_signed;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic [WIDTH-1:0] data_remainder;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_DIV, ctrl_signed,
        output data_operandA, data_operandB,
        input  data_result, data_remainder,
        input  data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_DIV, ctrl_signed,
        input  data_operandA, data_operandB,
        output data_result, data_remainder,
        output data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/divider_param.sv
// Restoring divider, one quotient bit per cycle, signed or unsigned.
// Divide-by-zero and signed overflow skip the iteration loop.
module divider_param #(
    parameter int WIDTH = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    divider_param_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic             q_neg;
    logic             r_neg;
    logic             exc_pend;
    logic             fix_ph;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] rem_q;
    logic             exc_q;
    logic             rdy_q;
    logic             busy_q;

    logic             start;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             ovf;
    logic [WIDTH:0]   sh;
    logic [WIDTH:0]   diff;
    logic             fits;

    always_comb begin
        start    = bus.ctrl_DIV && (state == IDLE || state == DONE);
        a_neg    = bus.ctrl_signed & bus.data_operandA[WIDTH-1];
        b_neg    = bus.ctrl_signed & bus.data_operandB[WIDTH-1];
        a_mag    = a_neg ? -bus.data_operandA : bus.data_operandA;
        b_mag    = b_neg ? -bus.data_operandB : bus.data_operandB;
        div_zero = (bus.data_operandB == '0);
        ovf      = bus.ctrl_signed
                 && (bus.data_operandA == MIN_NEG)
                 && (bus.data_operandB == '1);
        sh       = {rem, quot[WIDTH-1]};
        // rem < dvs keeps sh - dvs below 2^WIDTH, so bit WIDTH is the borrow
        diff     = sh - {1'b0, dvs};
        fits     = !diff[WIDTH];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            quot     <= '0;
            rem      <= '0;
            dvs      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            exc_pend <= 1'b0;
            fix_ph   <= 1'b0;
            result_q <= '0;
            rem_q    <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        exc_q  <= 1'b0;
                        cnt    <= '0;
                        dvs    <= b_mag;
                        if (div_zero || ovf) begin
                            quot     <= div_zero ? '1 : bus.data_operandA;
                            rem      <= div_zero ? bus.data_operandA : '0;
                            q_neg    <= 1'b0;
                            r_neg    <= 1'b0;
                            exc_pend <= 1'b1;
                            fix_ph   <= 1'b1;
                            state    <= FIX;
                        end else begin
                            quot     <= a_mag;
                            rem      <= '0;
                            q_neg    <= a_neg ^ b_neg;
                            r_neg    <= a_neg;
                            exc_pend <= 1'b0;
                            fix_ph   <= 1'b0;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    quot <= {quot[WIDTH-2:0], fits};
                    rem  <= fits ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    if (!fix_ph) begin
                        quot   <= q_neg ? -quot : quot;
                        rem    <= r_neg ? -rem : rem;
                        fix_ph <= 1'b1;
                    end else begin
                        result_q <= quot;
                        rem_q    <= rem;
                        exc_q    <= exc_pend;
                        rdy_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_remainder = rem_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = busy_q;
endmodule
